iter_compare_unit: RTL
======================

# iter_compare_unit

Parametrised multi-cycle compare/select unit, the next generation of the core's single-cycle `set_less_than`. It supports signed and unsigned less-than, equality, and min/max selection on `WIDTH`-bit operands. The comparison runs chunk-serially from the MSB chunk down, with early termination on the first differing chunk. The unit sits beside the ALU as a valid/ready functional unit, so compare width can scale without lengthening the ALU critical path.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `CHUNK`, 8: bits compared per cycle. Must divide `WIDTH`, and `NCHUNK = WIDTH/CHUNK` must be ≥ 2.

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept a request.
- `op_i`  in  3  operation, `cmp_op_e`.
- `rs1_i`  in  WIDTH  operand A.
- `rs2_i`  in  WIDTH  operand B.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts result.
- `rd_o`  out  WIDTH  result.

## Operation
Operation encodings (`op_i`):
- SLT=0, SLTU=1, SEQ=2, MIN=3, MINU=4, MAX=5, MAXU=6.
- 7 is reserved: `rd_o`=0, with normal latency.

Capture (accept = `valid_i && ready_o`):
- Latch `op_i`, the original `rs1_i`/`rs2_i` (used for min/max output), and working copies `a`/`b`.
- For signed ops (SLT, MIN, MAX), the MSB of `a` and `b` is inverted, giving offset binary. All scanning is then an unsigned compare.
- Chunk index `idx` is set to `NCHUNK-1`, width `$clog2(NCHUNK)`.

FSM states IDLE, SCAN, DONE:
- **IDLE:** `ready_o`=1. On accept, go to SCAN.
- **SCAN:** compare `a[idx*CHUNK +: CHUNK]` against the same chunk of `b`.
  - If the chunks differ: `lt` = (a chunk < b chunk), `eq`=0, go to DONE.
  - Else if `idx`==0: `lt`=0, `eq`=1, go to DONE.
  - Else decrement `idx`.
- **DONE:** `valid_o`=1 and `rd_o` is driven from registers. When `ready_i`=1, go to IDLE.

Result:
- SLT/SLTU: `{'0, lt}`.
- SEQ: `{'0, eq}`.
- MIN/MINU: `lt ? rs1 : rs2`.
- MAX/MAXU: `lt ? rs2 : rs1`.
- Ties return `rs1` in all min/max ops.

Handshake and reset:
- `ready_o`=0 in SCAN and DONE. `valid_i` is ignored there, with no queuing.
- `rd_o` and `valid_o` hold stable while `valid_o && !ready_i`.
- Reset values: state IDLE, `valid_o`=0, `rd_o`=0, `ready_o`=1, `idx`=0, all operand registers 0.
- Reset asserted in any state aborts the operation. No result is produced.

## Timing
- Accept at edge t. The first SCAN cycle is t..t+1.
- A difference in chunk k (counting from the top, k=0..NCHUNK-1) gives `valid_o`=1 after edge t+2+k.
- Best-case latency is 2 cycles. Worst case (equal operands, or difference only in the lowest chunk) is `NCHUNK+1` cycles. That is 5 cycles for 32/8.
- Result handshake at edge r: `ready_o`=1 after r. The next accept is possible at edge r+1. There is no same-cycle result/accept overlap.
- `ready_o` and `valid_o` decode from the state register only. There are no combinational input→output paths.

## Structure
- `cmp_pkg` holds:
  - `cmp_op_e` (3-bit enum, encodings above).
  - the `cmp_state_e` FSM enum.
  - a helper `is_signed_op()` and `is_minmax_op()` function.
- One sub-module, `chunk_cmp` (parameter `CHUNK`): combinational `lt`/`eq` of two `CHUNK`-bit slices. It is instantiated once and fed by the `idx`-selected slices.
- Elaboration assertion: `WIDTH % CHUNK == 0` and `NCHUNK >= 2`.

## Test plan
All scenarios use WIDTH=32, CHUNK=8, and `ready_i`=1 unless stated.
- SLT rs1=0xFFFF_FFFF, rs2=0x0000_0001 → `rd_o`=1, `valid_o` 2 cycles after accept. SLTU on the same operands → `rd_o`=0, 2 cycles.
- SEQ rs1=rs2=0x1234_5678 → `rd_o`=1 after 5 cycles. SEQ rs1=0x1234_5678, rs2=0x1234_5679 → `rd_o`=0 after 5 cycles.
- MIN 0x8000_0000 vs 0x7FFF_FFFF → 0x8000_0000. MAXU on the same → 0x8000_0000. MINU 5 vs 5 → 5 (rs1). `op_i`=7 → 0.
- Backpressure: hold `ready_i`=0 for 3 cycles in DONE → `rd_o`/`valid_o` stable, `ready_o`=0. A `valid_i` pulse during this window is not accepted. After the handshake, `ready_o`=1.
- Assert `rst_i` mid-SCAN (equal operands, third SCAN cycle) → `valid_o`=0 and `ready_o`=1 immediately. No result is ever presented for that request.
- 1000 random ops/operands with random `ready_i` stalls → every result matches the `$signed`/unsigned reference model, and latency equals 2+k for the first differing chunk k.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the iterative compare/select unit.
// Holds the op encoding, the FSM states and the op-class helpers.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_SLT  = 3'd0,
    OP_SLTU = 3'd1,
    OP_SEQ  = 3'd2,
    OP_MIN  = 3'd3,
    OP_MINU = 3'd4,
    OP_MAX  = 3'd5,
    OP_MAXU = 3'd6,
    OP_RSV  = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  function automatic logic is_signed_op(input cmp_op_e op);
    return (op == OP_SLT) || (op == OP_MIN) || (op == OP_MAX);
  endfunction

  function automatic logic is_minmax_op(input cmp_op_e op);
    return (op == OP_MIN) || (op == OP_MINU) ||
           (op == OP_MAX) || (op == OP_MAXU);
  endfunction

endpackage

// File: rtl/iter_compare_unit_chunk_cmp.sv
// Combinational unsigned compare of two chunk-wide slices.
// Produces less-than and equality flags.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/iter_compare_unit.sv
// Chunk-serial compare/select unit (SLT/SLTU/SEQ/MIN/MAX).
// Scans from the MSB chunk down and stops at the first difference.
module iter_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] rd_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK != 0) || (NCHUNK < 2)) begin : g_bad_cfg
    $error("iter_compare_unit: bad WIDTH/CHUNK");
  end

  cmp_state_e       state_q, state_d;
  cmp_op_e          op_q, op_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic             ch_lt, ch_eq;
  logic             sgn;

  assign a_ch = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_ch = b_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .a_i  (a_ch),
    .b_i  (b_ch),
    .lt_o (ch_lt),
    .eq_o (ch_eq)
  );

  function automatic logic [WIDTH-1:0] result(
    input cmp_op_e          op,
    input logic             lt,
    input logic             eq,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (op)
      OP_SLT, OP_SLTU: r = {{(WIDTH-1){1'b0}}, lt};
      OP_SEQ:          r = {{(WIDTH-1){1'b0}}, eq};
      OP_MIN, OP_MINU: r = lt ? x : y;
      OP_MAX, OP_MAXU: r = lt ? y : x;
      default:         r = '0;
    endcase
    return r;
  endfunction

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);
  assign rd_o    = rd_q;
  assign sgn     = is_signed_op(cmp_op_e'(op_i));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    fin_d   = fin_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          op_d  = cmp_op_e'(op_i);
          rs1_d = rs1_i;
          rs2_d = rs2_i;
          // Offset binary turns a signed compare into an unsigned one
          a_d   = rs1_i;
          b_d   = rs2_i;
          a_d[WIDTH-1] = rs1_i[WIDTH-1] ^ sgn;
          b_d[WIDTH-1] = rs2_i[WIDTH-1] ^ sgn;
          idx_d   = IW'(NCHUNK - 1);
          fin_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (fin_q) begin
          rd_d    = result(op_q, lt_q, eq_q, rs1_q, rs2_q);
          fin_d   = 1'b0;
          state_d = ST_DONE;
        end else if (!ch_eq) begin
          lt_d  = ch_lt;
          eq_d  = 1'b0;
          fin_d = 1'b1;
        end else if (idx_q == '0) begin
          lt_d  = 1'b0;
          eq_d  = 1'b1;
          fin_d = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SLT;
      rs1_q   <= '0;
      rs2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      fin_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      fin_q   <= fin_d;
      rd_q    <= rd_d;
    end
  end

endmodule
